// File: rtl/obstacle_engine.sv
// rtl/obstacle_engine.sv - dino game-play core: obstacle slots, speed ramp, spawn spacing, play FSM, score
module obstacle_engine #(
   parameter int          NUM_OBS           = 3,
   parameter int          X_WIDTH           = 10,
   parameter int          SPAWN_X           = 640,
   parameter int          MIN_GAP           = 160,
   parameter int          SPEED_INIT        = 1,
   parameter int          SPEED_MAX         = 8,
   parameter int          SPEED_STEP_FRAMES = 600,
   parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_tick,
   input  logic                       start,
   input  logic                       collision,
   output logic [NUM_OBS*X_WIDTH-1:0] obs_x,
   output logic [NUM_OBS-1:0]         obs_active,
   output logic [3:0]                 speed,
   output logic [15:0]                score,
   output logic                       game_over,
   output logic [1:0]                 state
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_OVER = 2'b10;

   logic [1:0]                 r_state;
   logic                       r_game_over;
   logic [NUM_OBS*X_WIDTH-1:0] r_obs_x;
   logic [NUM_OBS-1:0]         r_active;
   logic [3:0]                 r_speed;
   logic [15:0]                r_score;
   logic [15:0]                r_gap;
   logic [15:0]                r_frame_cnt;
   logic [15:0]                r_lfsr;

   logic [1:0]                 w_state_next;
   logic                       w_game_over_next;
   logic                       w_enter_run;
   logic                       w_tick_run;
   logic                       w_gap_zero;
   logic                       w_spawn_found;
   logic [NUM_OBS*X_WIDTH-1:0] w_obs_x_next;
   logic [NUM_OBS-1:0]         w_active_next;
   logic [7:0]                 w_clear_cnt;
   logic [16:0]                w_score_sum;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_game_over <= w_game_over_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (start)     w_state_next = ST_RUN;
         ST_RUN:  if (collision) w_state_next = ST_OVER;
         ST_OVER: if (start)     w_state_next = ST_RUN;
         default:                w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_game_over_next = (w_state_next == ST_OVER);
      w_enter_run      = (r_state != ST_RUN) && (w_state_next == ST_RUN);
      w_tick_run       = (r_state == ST_RUN) && frame_tick && !collision;
   end

   // Fibonacci LFSR, taps 16/14/13/11, free-running in every state
   always_ff @(posedge clk) begin
      if (reset) r_lfsr <= LFSR_SEED;
      else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   // Move/clear every active slot; the lowest slot inactive before the tick is the spawn candidate
   always_comb begin
      w_obs_x_next  = r_obs_x;
      w_active_next = r_active;
      w_clear_cnt   = 8'd0;
      w_spawn_found = 1'b0;
      w_gap_zero    = (r_gap == 16'd0);
      for (int i = 0; i < NUM_OBS; i++) begin
         if (r_active[i]) begin
            if (r_obs_x[i*X_WIDTH +: X_WIDTH] >= X_WIDTH'(r_speed)) begin
               w_obs_x_next[i*X_WIDTH +: X_WIDTH] = r_obs_x[i*X_WIDTH +: X_WIDTH] - X_WIDTH'(r_speed);
            end else begin
               w_active_next[i] = 1'b0;
               w_clear_cnt      = w_clear_cnt + 8'd1;
            end
         end else if (!w_spawn_found) begin
            w_spawn_found = 1'b1;
            if (w_gap_zero) begin
               w_obs_x_next[i*X_WIDTH +: X_WIDTH] = X_WIDTH'(SPAWN_X);
               w_active_next[i]                   = 1'b1;
            end
         end
      end
      w_score_sum = {1'b0, r_score} + 17'(w_clear_cnt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_obs_x     <= '0;
         r_active    <= '0;
         r_speed     <= 4'(SPEED_INIT);
         r_score     <= 16'd0;
         r_gap       <= 16'd0;
         r_frame_cnt <= 16'd0;
      end else if (w_enter_run) begin
         r_active    <= '0;
         r_speed     <= 4'(SPEED_INIT);
         r_score     <= 16'd0;
         r_gap       <= 16'd0;
         r_frame_cnt <= 16'd0;
      end else if (w_tick_run) begin
         r_obs_x  <= w_obs_x_next;
         r_active <= w_active_next;
         r_score  <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
         if (w_gap_zero && w_spawn_found)
            r_gap <= 16'(MIN_GAP) + {8'd0, r_lfsr[7:0]};
         else if (r_gap >= {12'd0, r_speed})
            r_gap <= r_gap - {12'd0, r_speed};
         else
            r_gap <= 16'd0;
         if (r_frame_cnt == 16'(SPEED_STEP_FRAMES - 1)) begin
            r_frame_cnt <= 16'd0;
            if (r_speed < 4'(SPEED_MAX)) r_speed <= r_speed + 4'd1;
         end else begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign obs_x      = r_obs_x;
   assign obs_active = r_active;
   assign speed      = r_speed;
   assign score      = r_score;
   assign game_over  = r_game_over;
   assign state      = r_state;

endmodule

// File: tb/tb_obstacle_engine.sv
// tb/tb_obstacle_engine.sv - directed self-checking bench for obstacle_engine
module tb_obstacle_engine;

   logic       clk = 1'b0;
   logic [2:0] reset_v = 3'b111;
   logic [2:0] start_v = 3'b000;
   logic [2:0] tick_v  = 3'b000;
   logic [2:0] coll_v  = 3'b000;

   logic [29:0] a_obs_x;  logic [2:0] a_act;  logic [3:0] a_speed;  logic [15:0] a_score;  logic a_go;  logic [1:0] a_state;
   logic [29:0] b_obs_x;  logic [2:0] b_act;  logic [3:0] b_speed;  logic [15:0] b_score;  logic b_go;  logic [1:0] b_state;
   logic [9:0]  c_obs_x;  logic [0:0] c_act;  logic [3:0] c_speed;  logic [15:0] c_score;  logic c_go;  logic [1:0] c_state;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   obstacle_engine #(.SPEED_STEP_FRAMES(1000)) u_a (
      .clk(clk), .reset(reset_v[0]), .frame_tick(tick_v[0]), .start(start_v[0]), .collision(coll_v[0]),
      .obs_x(a_obs_x), .obs_active(a_act), .speed(a_speed), .score(a_score), .game_over(a_go), .state(a_state));

   obstacle_engine #(.SPEED_STEP_FRAMES(4), .SPEED_MAX(3)) u_b (
      .clk(clk), .reset(reset_v[1]), .frame_tick(tick_v[1]), .start(start_v[1]), .collision(coll_v[1]),
      .obs_x(b_obs_x), .obs_active(b_act), .speed(b_speed), .score(b_score), .game_over(b_go), .state(b_state));

   obstacle_engine #(.NUM_OBS(1), .MIN_GAP(0), .SPAWN_X(300), .SPEED_STEP_FRAMES(1000)) u_c (
      .clk(clk), .reset(reset_v[2]), .frame_tick(tick_v[2]), .start(start_v[2]), .collision(coll_v[2]),
      .obs_x(c_obs_x), .obs_active(c_act), .speed(c_speed), .score(c_score), .game_over(c_go), .state(c_state));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input int k);
      start_v[k] = 1'b1; step(); start_v[k] = 1'b0;
   endtask

   task automatic do_tick(input int k);
      tick_v[k] = 1'b1; step(); tick_v[k] = 1'b0;
   endtask

   initial begin
      // reset held 2 cycles while start and frame_tick are high
      start_v = 3'b111; tick_v = 3'b111; coll_v = 3'b111;
      step(); step();
      check("rst_state", 32'(a_state), 32'd0);
      check("rst_active", 32'(a_act), 32'd0);
      check("rst_obs_x", 32'(a_obs_x), 32'd0);
      check("rst_score", 32'(a_score), 32'd0);
      check("rst_speed", 32'(a_speed), 32'd1);
      check("rst_game_over", 32'(a_go), 32'd0);
      reset_v = 3'b000; start_v = 3'b000; tick_v = 3'b000; coll_v = 3'b000;
      step();
      do_tick(0);
      check("idle_tick_ignored", 32'(a_act), 32'd0);
      check("idle_state", 32'(a_state), 32'd0);

      // A: spawn, move, slot1 held off by the gap, clear and score
      do_start(0);
      check("a_start_state", 32'(a_state), 32'd1);
      do_tick(0);
      check("a_spawn_active", 32'(a_act), 32'b001);
      check("a_spawn_x", 32'(a_obs_x[9:0]), 32'd640);
      for (int t = 2; t <= 4; t++) begin
         do_tick(0);
         check("a_move_x", 32'(a_obs_x[9:0]), 32'(641 - t));
      end
      for (int t = 5; t <= 161; t++) do_tick(0);
      check("a_slot1_wait", 32'(a_act[1]), 32'd0);
      check("a_x_161", 32'(a_obs_x[9:0]), 32'd480);
      for (int t = 162; t <= 641; t++) do_tick(0);
      check("a_x_zero", 32'(a_obs_x[9:0]), 32'd0);
      check("a_x_zero_active", 32'(a_act[0]), 32'd1);
      check("a_score_before", 32'(a_score), 32'd0);
      do_tick(0);
      check("a_cleared", 32'(a_act[0]), 32'd0);
      check("a_score_one", 32'(a_score), 32'd1);
      check("a_slot1_spawned", 32'(a_act[1]), 32'd1);

      // B: speed ramp every 4 ticks, ceiling 3, then collision race and restart
      do_start(1);
      for (int t = 1; t <= 12; t++) begin
         do_tick(1);
         if (t == 3)  check("b_speed_t3", 32'(b_speed), 32'd1);
         if (t == 4)  check("b_speed_t4", 32'(b_speed), 32'd2);
         if (t == 7)  check("b_speed_t7", 32'(b_speed), 32'd2);
         if (t == 8)  check("b_speed_t8", 32'(b_speed), 32'd3);
         if (t == 12) check("b_speed_t12", 32'(b_speed), 32'd3);
      end
      check("b_x_t12", 32'(b_obs_x[9:0]), 32'd617);
      coll_v[1] = 1'b1; tick_v[1] = 1'b1; step(); coll_v[1] = 1'b0; tick_v[1] = 1'b0;
      check("b_coll_state", 32'(b_state), 32'd2);
      check("b_coll_game_over", 32'(b_go), 32'd1);
      check("b_coll_x", 32'(b_obs_x[9:0]), 32'd617);
      check("b_coll_score", 32'(b_score), 32'd0);
      do_tick(1); do_tick(1);
      check("b_over_x", 32'(b_obs_x[9:0]), 32'd617);
      check("b_over_active", 32'(b_act), 32'b001);
      check("b_over_speed", 32'(b_speed), 32'd3);
      do_start(1);
      check("b_restart_state", 32'(b_state), 32'd1);
      check("b_restart_active", 32'(b_act), 32'd0);
      check("b_restart_score", 32'(b_score), 32'd0);
      check("b_restart_speed", 32'(b_speed), 32'd1);
      check("b_restart_game_over", 32'(b_go), 32'd0);

      // C: single slot, spawn deferred while it is occupied
      do_start(2);
      do_tick(2);
      check("c_spawn_x", 32'(c_obs_x), 32'd300);
      for (int t = 2; t <= 301; t++) begin
         do_tick(2);
         check("c_held_active", 32'(c_act), 32'd1);
         check("c_held_x", 32'(c_obs_x), 32'(301 - t));
      end
      do_tick(2);
      check("c_clear_active", 32'(c_act), 32'd0);
      check("c_clear_score", 32'(c_score), 32'd1);
      do_tick(2);
      check("c_respawn_active", 32'(c_act), 32'd1);
      check("c_respawn_x", 32'(c_obs_x), 32'd300);
      do_tick(2); do_tick(2);
      reset_v[2] = 1'b1; start_v[2] = 1'b1; tick_v[2] = 1'b1; coll_v[2] = 1'b1;
      step();
      reset_v[2] = 1'b0; start_v[2] = 1'b0; tick_v[2] = 1'b0; coll_v[2] = 1'b0;
      check("c_mid_rst_state", 32'(c_state), 32'd0);
      check("c_mid_rst_active", 32'(c_act), 32'd0);
      check("c_mid_rst_x", 32'(c_obs_x), 32'd0);
      check("c_mid_rst_score", 32'(c_score), 32'd0);
      check("c_mid_rst_speed", 32'(c_speed), 32'd1);
      check("c_mid_rst_game_over", 32'(c_go), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/obstacle_engine.md
# obstacle_engine

Parametrised game-play core for the VGA dino game: owns up to NUM_OBS scrolling obstacles, per-frame movement at a ramping speed, pseudo-random spawn spacing, a play-state machine (IDLE/RUN/OVER), and a score counter. It advances once per frame on the VGA timing generator's end-of-frame pulse. It consumes the renderer's pixel-overlap collision flag and exports obstacle positions back to the renderer. It is the multi-obstacle, variable-speed, restartable successor to the single hard-wired cactus mover.

## Interface
Parameters:
- NUM_OBS, 3: number of obstacle slots.
- X_WIDTH, 10: width of one obstacle x coordinate.
- SPAWN_X, 640: x loaded into a newly spawned obstacle.
- MIN_GAP, 160: minimum spawn spacing, in pixels.
- SPEED_INIT, 1: pixels/frame on entry to RUN.
- SPEED_MAX, 8: speed ceiling; must be ≤ 15.
- SPEED_STEP_FRAMES, 600: RUN frames per +1 speed step.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame (screenEnd, resynchronised to clk upstream).
- start  in  1  level; sampled every cycle.
- collision  in  1  renderer flag: dino pixel overlaps obstacle pixel.
- obs_x  out  NUM_OBS*X_WIDTH  packed x positions; slot i at [i*X_WIDTH +: X_WIDTH].
- obs_active  out  NUM_OBS  slot-valid bits; the renderer ignores inactive slots.
- speed  out  4  current pixels/frame.
- score  out  16  obstacles cleared this run.
- game_over  out  1  high while state is OVER.
- state  out  2  00 IDLE, 01 RUN, 10 OVER.

## Operation
- All outputs are registered.
- Reset values: state IDLE, obs_active 0, obs_x 0, speed SPEED_INIT, score 0, game_over 0, gap counter 0, frame counter 0, LFSR LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Steps every clk cycle in every state.
- FSM transitions:
  - IDLE: start → RUN.
  - RUN: collision → OVER.
  - OVER: start → RUN.
  - No other transitions.
- Entry to RUN from either IDLE or OVER, same edge as the transition: obs_active 0, score 0, speed SPEED_INIT, gap counter 0, frame counter 0.
- IDLE and OVER: obstacles, score, and speed hold; frame_tick is ignored.
- RUN, on a frame_tick with collision low, using values held before the tick:
  - Move: each active slot with x ≥ speed takes x − speed.
  - Clear: each active slot with x < speed is deactivated. score increases by the count of such slots, saturating at 16'hFFFF.
  - Gap: gap counter takes max(gap − speed, 0).
  - Spawn: if gap was already 0 before this tick and some slot was inactive before this tick, the lowest-index such slot gets x = SPAWN_X and active = 1. The gap counter is then reloaded with MIN_GAP + LFSR[7:0] instead of being decremented.
  - At most one spawn per tick. A slot freed on this tick is not reused on the same tick.
  - If gap is 0 and all slots are full, the spawn is deferred and gap stays 0.
  - Speed: frame counter increments. At SPEED_STEP_FRAMES−1 it wraps to 0 and speed increments, saturating at SPEED_MAX.
- collision and frame_tick in the same RUN cycle: collision wins. Go to OVER with no movement, spawn, or score change.
- collision outside RUN is ignored.
- Reset asserted in any state, mid-frame included, forces all reset values on the next edge and overrides start, collision, and frame_tick.

## Timing
- frame_tick sampled in cycle n → new obs_x, obs_active, score, and speed visible in cycle n+1.
- collision in cycle n (RUN) → state OVER and game_over = 1 in cycle n+1. Positions frozen from cycle n+1 onward.
- start in cycle n → state RUN in cycle n+1. The first spawn happens on the first frame_tick after that.
- game_over is registered as (next state == OVER). It never lags state.
- No internal combinational path from any input to any output.

## Test plan
- Reset: hold reset 2 cycles with start and frame_tick high → state 00, obs_active 000, score 0, speed 1, game_over 0.
- Spawn and move:
  - Setup: start 1 cycle, then frame_tick.
  - Slot0 active, x = 640.
  - Next 3 ticks → x = 639, 638, 637.
  - Slot1 stays inactive until the gap reaches 0.
- Clear and score: force slot0 to x = 1 via ticks at speed 1 → after the tick with x = 0, slot0 x = 0. Next tick → slot0 inactive, score = 1.
- Speed ramp: SPEED_STEP_FRAMES = 4, SPEED_MAX = 3 → speed 1→2 after tick 4 and 2→3 after tick 8. Stays 3 after tick 12.
- Collision race:
  - Stimulus: collision and frame_tick in the same cycle.
  - Expected: next cycle state 10, game_over 1, obs_x unchanged.
  - Later ticks: no change.
  - Then start → state 01, obs_active 0, score 0, speed 1.
- Slots full: NUM_OBS = 1, MIN_GAP = 0 → a second spawn is deferred while slot0 is active. The spawn occurs on the tick after slot0 clears, not on the same tick. Reset asserted mid-RUN → all reset values next cycle.
